// File: rtl/ascon_perm_if.sv
// Handshake bundle between the ASCON mode FSM / round counter and the permutation controller.
interface ascon_perm_if;
    logic       start_a_i;
    logic       start_b_i;
    logic [3:0] count_i;
    logic       ena_cnt_o;
    logic       init_a_o;
    logic       init_b_o;
    logic       state_en_o;
    logic       sel_in_o;
    logic [7:0] round_const_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        output start_a_i, start_b_i, count_i,
        input  ena_cnt_o, init_a_o, init_b_o, state_en_o, sel_in_o,
               round_const_o, busy_o, done_o
    );

    modport slave (
        input  start_a_i, start_b_i, count_i,
        output ena_cnt_o, init_a_o, init_b_o, state_en_o, sel_in_o,
               round_const_o, busy_o, done_o
    );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// Sequences p^a / p^b runs over the shared round counter and decodes the
// per-round datapath controls and constant from the counter value.
module ascon_perm_ctrl #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 8
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    ascon_perm_if.slave  bus
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS_A - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic   first_q, first_d;

    always_comb begin
        state_d         = state_q;
        first_d         = first_q;
        bus.ena_cnt_o   = 1'b0;
        bus.init_a_o    = 1'b0;
        bus.init_b_o    = 1'b0;
        bus.state_en_o  = 1'b0;
        bus.sel_in_o    = 1'b0;
        bus.busy_o      = 1'b0;
        bus.done_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Gate the start decode so every control stays low while reset is held.
                if (resetb_i && bus.start_a_i) begin
                    bus.ena_cnt_o = 1'b1;
                    bus.init_a_o  = 1'b1;
                    first_d       = 1'b1;
                    state_d       = ROUND;
                end else if (resetb_i && bus.start_b_i) begin
                    bus.ena_cnt_o = 1'b1;
                    bus.init_b_o  = 1'b1;
                    first_d       = 1'b1;
                    state_d       = ROUND;
                end
            end
            ROUND: begin
                bus.busy_o     = 1'b1;
                bus.state_en_o = 1'b1;
                bus.sel_in_o   = first_q;
                first_d        = 1'b0;
                // Out-of-range counts are treated as the last round so a run always ends.
                if (bus.count_i >= LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    bus.ena_cnt_o = 1'b1;
                end
            end
            DONE: begin
                bus.done_o = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    assign bus.round_const_o = {4'hF - bus.count_i, bus.count_i};

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: combinational vector table, directed multi-cycle
// sequences and random starts checked against a per-run schedule model.
module tb_ascon_perm_ctrl;

    localparam int RA = 12;
    localparam int RB = 8;

    logic clock;
    logic resetb;

    ascon_perm_if bus();

    ascon_perm_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
        .clock_i  (clock),
        .resetb_i (resetb),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Round counter behaviour the controller expects to drive.
    logic [3:0] cnt_q = 4'd0;
    logic       cnt_force = 1'b1;
    logic [3:0] cnt_val = 4'd0;

    always @(posedge clock) begin
        if (bus.ena_cnt_o)
            cnt_q <= bus.init_a_o ? 4'd0 : (bus.init_b_o ? 4'(RA - RB) : cnt_q + 4'd1);
    end

    assign bus.count_i = cnt_force ? cnt_val : cnt_q;

    int nchk = 0;
    int nerr = 0;
    int ndone = 0;

    logic [14:0] exp_q[$];

    typedef struct {
        bit         rstb;
        bit         a;
        bit         b;
        logic [3:0] cnt;
        logic [14:0] exp;
    } vec_t;

    function automatic logic [7:0] rconst(int i);
        return 8'((((15 - i) & 15) * 16) + (i & 15));
    endfunction

    function automatic logic [14:0] pk(bit ena, bit ia, bit ib, bit se, bit si,
                                       bit bz, bit dn, logic [7:0] rc);
        return {ena, ia, ib, se, si, bz, dn, rc};
    endfunction

    function automatic logic [14:0] act();
        return {bus.ena_cnt_o, bus.init_a_o, bus.init_b_o, bus.state_en_o,
                bus.sel_in_o, bus.busy_o, bus.done_o, bus.round_const_o};
    endfunction

    task automatic check(string name, logic [14:0] got, logic [14:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h (ena,ia,ib,se,si,busy,done,rc) expected %h", name, got, want);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        nchk++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // A run is a list of rounds first_idx..RA-1 followed by one done cycle.
    task automatic push_run(int first_idx);
        for (int i = first_idx; i < RA; i++)
            exp_q.push_back(pk(i < RA - 1, 1'b0, 1'b0, 1'b1, i == first_idx, 1'b1, 1'b0, rconst(i)));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rconst(RA - 1)));
    endtask

    task automatic step(string name, bit a, bit b);
        logic [14:0] e;
        @(posedge clock);
        #1;
        bus.start_a_i = a;
        bus.start_b_i = b;
        @(negedge clock);
        if (exp_q.size() == 0) begin
            e = pk(a | b, a, !a && b, 1'b0, 1'b0, 1'b0, 1'b0, rconst(int'(cnt_q)));
            check(name, act(), e);
            if (a)      push_run(0);
            else if (b) push_run(RA - RB);
        end else begin
            e = exp_q.pop_front();
            check(name, act(), e);
        end
        if (bus.done_o) ndone++;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(name, 1'b0, 1'b0);
        check_int({name, "_drained"}, exp_q.size(), 0);
    endtask

    vec_t vecs[$];

    initial begin
        resetb = 1'b0;
        bus.start_a_i = 1'b0;
        bus.start_b_i = 1'b0;

        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0,  pk(0,0,0,0,0,0,0, 8'hF0)});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd4,  pk(0,0,0,0,0,0,0, 8'hB4)});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd11, pk(0,0,0,0,0,0,0, 8'h4B)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd15, pk(0,0,0,0,0,0,0, 8'h0F)});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd3,  pk(0,0,0,0,0,0,0, 8'hC3)});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd7,  pk(1,1,0,0,0,0,0, 8'h87)});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'd9,  pk(1,0,1,0,0,0,0, 8'h69)});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd2,  pk(1,1,0,0,0,0,0, 8'hD2)});

        // Starts are dropped again before the next edge so the FSM stays in IDLE.
        foreach (vecs[k]) begin
            @(posedge clock);
            #1;
            resetb = vecs[k].rstb;
            bus.start_a_i = vecs[k].a;
            bus.start_b_i = vecs[k].b;
            cnt_val = vecs[k].cnt;
            #1;
            check($sformatf("vec%0d", k), act(), vecs[k].exp);
            bus.start_a_i = 1'b0;
            bus.start_b_i = 1'b0;
        end
        cnt_force = 1'b0;

        // p^a, p^b and simultaneous starts
        ndone = 0;
        step("pa_start", 1'b1, 1'b0);
        drain("pa_run");
        step("pb_start", 1'b0, 1'b1);
        drain("pb_run");
        step("ab_start", 1'b1, 1'b1);
        drain("ab_run");
        check_int("three_runs_done", ndone, 3);

        // start_b during an active p^a run is ignored
        ndone = 0;
        step("ign_start", 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step("ign_b", 1'b0, 1'b1);
        drain("ign_run");
        check_int("ign_single_done", ndone, 1);

        // Asynchronous reset in round 5 of p^a
        ndone = 0;
        step("rst_start", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("rst_round", 1'b0, 1'b0);
        @(posedge clock);
        #3;
        resetb = 1'b0;
        #1;
        check("rst_async", act(), pk(0,0,0,0,0,0,0, rconst(int'(cnt_q))));
        exp_q.delete();
        @(posedge clock);
        #2;
        check("rst_held", act(), pk(0,0,0,0,0,0,0, rconst(int'(cnt_q))));
        resetb = 1'b1;
        for (int i = 0; i < 3; i++) step("rst_idle", 1'b0, 1'b0);
        check_int("rst_no_done", ndone, 0);
        step("rst_restart", 1'b1, 1'b0);
        drain("rst_rerun");
        check_int("rst_rerun_done", ndone, 1);

        // start_a held continuously: runs of accept + 12 rounds + done
        ndone = 0;
        for (int i = 0; i < 3 * (RA + 2); i++) step("held_a", 1'b1, 1'b0);
        check_int("held_three_done", ndone, 3);
        drain("held_run");

        // Random starts
        for (int i = 0; i < 600; i++)
            step("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        drain("rand_run");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ascon_perm_ctrl.md
Name: ascon_perm_ctrl

Overview:
Control FSM for the ASCON permutation datapath. It runs either a p^a (12-round) or a p^b (8-round) permutation. It drives the enable and init inputs of the shared round counter and consumes that counter's 4-bit value. From the counter value it produces the per-round constant, the state-register enable, the input/feedback select, and busy/done status for the top-level ASCON mode FSM.

Parameters:
ROUNDS_A, 12, rounds in p^a; the last round index is ROUNDS_A-1.
ROUNDS_B, 8, rounds in p^b; the counter is preloaded to ROUNDS_A-ROUNDS_B.

Ports:
clock_i  in  1  system clock, rising edge.
resetb_i  in  1  asynchronous reset, active-low.
start_a_i  in  1  request a p^a run; sampled only in IDLE.
start_b_i  in  1  request a p^b run; sampled only in IDLE.
count_i  in  4  current round index from the round counter.
ena_cnt_o  out  1  round counter enable.
init_a_o  out  1  load the counter with 0.
init_b_o  out  1  load the counter with ROUNDS_A-ROUNDS_B.
state_en_o  out  1  state register capture enable.
sel_in_o  out  1  1 = datapath takes the external state input; 0 = permutation feedback.
round_const_o  out  8  ASCON round constant for count_i.
busy_o  out  1  permutation in progress.
done_o  out  1  single-cycle completion pulse.

Behaviour:
- Reset is resetb_i: asynchronous, active-low; clock is clock_i. While reset is asserted:
  - FSM is forced to IDLE and the first-round flag is cleared.
  - Every output is 0 except round_const_o, which stays combinational from count_i.
- States: IDLE, ROUND, DONE. The state register and first-round flag are sequential; all outputs are decoded combinationally from state, count_i and the starts.
- IDLE:
  - busy_o=0, state_en_o=0.
  - If start_a_i=1: ena_cnt_o=1, init_a_o=1; set first flag; next state ROUND.
  - Else if start_b_i=1: ena_cnt_o=1, init_b_o=1; set first flag; next state ROUND.
  - If both starts are high, start_a_i wins.
- ROUND:
  - busy_o=1, state_en_o=1.
  - sel_in_o=first flag; the flag clears after the first ROUND cycle.
  - ena_cnt_o=1 unless count_i >= ROUNDS_A-1; at the last round the counter holds.
  - init_a_o=init_b_o=0.
  - If count_i >= ROUNDS_A-1, next state DONE; out-of-range values are treated as the last round. Otherwise stay in ROUND.
- DONE: done_o=1, busy_o=0, all other controls 0; next state IDLE unconditionally.
- round_const_o = {4'(15-count_i), count_i}.
  - Examples: count 0 -> 0xF0, 4 -> 0xB4, 11 -> 0x4B.
  - 4-bit modular arithmetic; valid for 0..11.
- Latency, with the start accepted at cycle 0:
  - p^a: ROUND in cycles 1..12, done_o in cycle 13.
  - p^b: ROUND in cycles 1..8, done_o in cycle 9.
  - A new start is accepted in the cycle after done_o; back-to-back runs have a 2-cycle gap.
- Starts asserted in ROUND or DONE are ignored, not queued.
- Reset mid-run aborts immediately to IDLE; no done_o is issued.

Test Plan:
- Reset then 1-cycle start_a_i -> init_a_o=1 in cycle 0; state_en_o high for 12 cycles with round_const_o F0,E1,D2,...,4B; sel_in_o=1 only in cycle 1; done_o=1 in cycle 13 only.
- 1-cycle start_b_i -> init_b_o=1; 8 ROUND cycles with constants B4,A5,96,87,78,69,5A,4B; done_o in cycle 9.
- start_a_i and start_b_i together -> init_a_o=1, init_b_o=0; 12-round run.
- start_b_i pulsed during an active p^a run -> ignored; the run still produces exactly 12 rounds and one done_o.
- resetb_i low at round 5 of p^a -> busy_o=0 and all controls 0 asynchronously; no done_o; a fresh start afterwards runs the full 12 rounds.
- start_a_i held high continuously -> repeated 12-round runs, each separated by a DONE cycle and an IDLE cycle; ena_cnt_o=0 in each last round.
